pythag_leg_solver: RTL and testbench
====================================

# pythag_leg_solver

Multi-cycle inverse of the hypotenuse unit: given hypotenuse `r` and one leg `x`, computes the other leg `y = floor(sqrt(r^2 - x^2))`. It sits beside the magnitude block in the same tile and lets a host round-trip `(x, y) -> r -> y`. Squaring uses shift-and-add and the root uses bit-serial trial subtraction, so the block has no multiplier. A start/busy/done handshake gives a fixed latency.

## Interface
Parameters: none (all widths fixed at 8-bit operands, 16-bit internals).

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ena` input 1: clock enable. When low, every register holds its value. `rst` still takes effect when `ena` is low.
- `start` input 1: request. Sampled only in IDLE.
- `r` input 8: hypotenuse, unsigned. Latched on accept.
- `x` input 8: known leg, unsigned. Latched on accept.
- `y` output 8: result leg. Registered, and holds its value until the next done.
- `done` output 1: one-cycle pulse (while `ena` is high) marking `y`/`err` valid.
- `busy` output 1: high from the accept edge until the done edge.
- `err` output 1: set with done when `x > r`. Otherwise cleared with done.

## Operation
- FSM states: IDLE, SQ, SUB, RT.
- IDLE:
  - If `start=1` at an edge, latch `r` and `x`, clear the accumulators, set `busy`, and go to SQ with `cnt=0`.
  - Operand changes after the accept edge have no effect.
- SQ (8 edges):
  - Each edge adds `(operand << cnt)` to its 16-bit accumulator when bit `cnt` of the multiplier copy is 1. This runs for `r*r` and `x*x` in parallel.
  - `cnt` goes 0..7. After the 8th edge, go to SUB.
- SUB (1 edge):
  - `diff = r2 - x2` if `r2 >= x2`. Otherwise `diff = 0` and the internal error flag is set.
  - Clear the trial result and go to RT with bit index 7.
- RT (8 edges, bits 7..0):
  - Trial `t = res | (1<<b)`. If `t*t <= diff`, then `res = t`.
  - `t*t` is formed without `*`: either an incremental remainder (restoring square root) or shift-add. Internal width is at least 17 bits so there is no overflow.
  - On the bit-0 edge: load `y <= res`, `err <= flag`, `done <= 1`, `busy <= 0`, and return to IDLE.
- Result is floor of the root. Max `diff = 65025`, giving `y <= 255` with no truncation.
- `start` while busy is ignored (not queued).
- `ena=0` freezes the FSM, counters, accumulators and outputs, including a pending `done`. The sequence resumes exactly where it stopped.

## Timing
- Reset values: `y=0`, `done=0`, `busy=0`, `err=0`, state IDLE, all internals 0.
- The accept edge is E0. SQ runs on E1–E8, SUB on E9, RT on E10–E17.
- `done`, `y` and `err` are updated at E17, so `done` is high for the cycle between E17 and E18. Latency from accept to done is 17 edges (with `ena` continuously high).
- `busy` is high from after E0 through E17.
- The earliest next accept is E18. With `start` held high continuously, the throughput is one result per 18 edges.
- `done` clears at the next enabled edge.
- `rst` mid-operation: at that edge, return to IDLE with all outputs 0. No `done` is ever produced for the aborted request.
- `rst` and `start` at the same edge: reset wins and `start` is not accepted.

## Test plan
- `r=5, x=3`, pulse `start` -> `done` 17 edges later, `y=4`, `err=0`. `busy` is high for exactly 17 cycles.
- `r=10, x=3` (diff 91) -> `y=9` (floor). `r=13, x=12` -> `y=5`. `r=255, x=0` -> `y=255`. `r=0, x=0` -> `y=0`. All with `err=0`.
- `r=3, x=5` -> `y=0`, `err=1`. The following request `r=5, x=4` -> `y=3`, `err=0`.
- Hold `start=1` with `r`/`x` changed every cycle -> operands captured only at E0 and E18. Results match those captured values, and `done` pulses exactly 18 edges apart.
- Drop `ena` for 5 cycles at E12 -> `done` is delayed by exactly 5 cycles and `y` is unchanged in value. Drop `ena` during the `done` cycle -> `done` stays high until `ena` returns.
- Assert `rst` at E6 of `r=200, x=100` -> outputs are 0 the next cycle and no `done` appears. A new request `r=200, x=120` gives `y=160`.

Source files
------------

// File: rtl/pythag_leg_solver_if.sv
// pythag_leg_solver_if
//   Host-side bundle for the leg solver.
//   master : host   (drives ena, start, r, x; observes y, done, busy, err)
//   slave  : solver (observes ena, start, r, x; drives y, done, busy, err)
//   ena   - clock enable, freezes the solver when low
//   start - request, only looked at while the solver is idle
//   r, x  - hypotenuse and known leg, unsigned 8-bit
//   y     - result leg, held until the next done
//   done  - one-cycle result-valid pulse
//   busy  - request in flight
//   err   - x was larger than r
interface pythag_leg_solver_if;
    logic       ena;
    logic       start;
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] y;
    logic       done;
    logic       busy;
    logic       err;

    modport master (
        output ena, start, r, x,
        input  y, done, busy, err
    );

    modport slave (
        input  ena, start, r, x,
        output y, done, busy, err
    );
endinterface

// File: rtl/pythag_leg_solver.sv
// pythag_leg_solver
//   Computes y = floor(sqrt(r^2 - x^2)) with no multiplier: both squares
//   are built by shift-and-add over 8 cycles, one cycle subtracts, and the
//   root is resolved one bit per cycle from MSB down. Fixed 17-edge latency
//   from accept to done.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, effective even while ena is low
//   bus  - slave side of pythag_leg_solver_if (ena/start/r/x in,
//          y/done/busy/err out)
module pythag_leg_solver (
    input logic                 clk,
    input logic                 rst,
    pythag_leg_solver_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SQ, SUB, RT} state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  r_q;
    logic [7:0]  x_q;
    logic [15:0] r2;
    logic [15:0] x2;
    logic [15:0] diff;
    logic [2:0]  cnt;       // SQ: multiplier bit index; RT: root bit index
    logic        flag;
    logic [7:0]  res;
    logic [17:0] res_sq;    // always equals res*res

    logic [7:0]  y_q;
    logic        done_q;
    logic        busy_q;
    logic        err_q;

    logic [15:0] r_pp;
    logic [15:0] x_pp;
    logic [7:0]  trial;
    logic [17:0] trial_sq;
    logic        take;

    // Partial products for the current multiplier bit.
    always_comb begin
        r_pp = 16'd0;
        x_pp = 16'd0;
        if (r_q[cnt]) r_pp = {8'd0, r_q} << cnt;
        if (x_q[cnt]) x_pp = {8'd0, x_q} << cnt;
    end

    // Bits below cnt are still zero in res, so (res | 2^b)^2 expands to
    // res^2 + res*2^(b+1) + 2^(2b) -- only shifts and adds.
    always_comb begin
        trial    = res | (8'd1 << cnt);
        trial_sq = res_sq
                 + ({9'd0, res, 1'b0} << cnt)
                 + (18'd1 << {cnt, 1'b0});
        take     = (trial_sq <= {2'b00, diff});
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (bus.ena)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start)   state_next = SQ;
            SQ:   if (cnt == 3'd7) state_next = SUB;
            SUB:                   state_next = RT;
            RT:   if (cnt == 3'd0) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= 8'd0;
            x_q    <= 8'd0;
            r2     <= 16'd0;
            x2     <= 16'd0;
            diff   <= 16'd0;
            cnt    <= 3'd0;
            flag   <= 1'b0;
            res    <= 8'd0;
            res_sq <= 18'd0;
            y_q    <= 8'd0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (bus.ena) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r_q    <= bus.r;
                        x_q    <= bus.x;
                        r2     <= 16'd0;
                        x2     <= 16'd0;
                        flag   <= 1'b0;
                        cnt    <= 3'd0;
                        busy_q <= 1'b1;
                    end
                end
                SQ: begin
                    r2  <= r2 + r_pp;
                    x2  <= x2 + x_pp;
                    cnt <= cnt + 3'd1;    // wraps 7 -> 0 on leaving SQ
                end
                SUB: begin
                    if (r2 >= x2) begin
                        diff <= r2 - x2;
                        flag <= 1'b0;
                    end else begin
                        diff <= 16'd0;
                        flag <= 1'b1;
                    end
                    res    <= 8'd0;
                    res_sq <= 18'd0;
                    cnt    <= 3'd7;
                end
                RT: begin
                    if (take) begin
                        res    <= trial;
                        res_sq <= trial_sq;
                    end
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        y_q    <= take ? trial : res;
                        err_q  <= flag;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y    = y_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_pythag_leg_solver.sv
module tb_pythag_leg_solver;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pythag_leg_solver_if bus ();

    pythag_leg_solver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: leg from the Pythagorean rule, root by plain search.
    function automatic void model(input int rr, input int xx,
                                  output int ey, output int ee);
        int d;
        ee = (xx > rr) ? 1 : 0;
        d  = ee ? 0 : rr * rr - xx * xx;
        ey = 0;
        while ((ey + 1) * (ey + 1) <= d) ey++;
    endfunction

    // Issue one request from idle and wait for done (bounded).
    // lat = edges from accept to done, -1 on timeout.
    task automatic issue(input int rr, input int xx, output int lat,
                         output int busy_n, output int yv, output int ev);
        @(negedge clk);
        bus.r = 8'(rr); bus.x = 8'(xx); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; busy_n = 0;
        if (bus.busy) busy_n++;
        while (!bus.done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
        end
        if (!bus.done) lat = -1;
        yv = int'(bus.y);
        ev = int'(bus.err);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.ena = 1'b1; bus.start = 1'b0; bus.r = 8'd0; bus.x = 8'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.y !== 8'd0) begin n_bad++; $display("FAIL reset_y got %0d want 0", bus.y); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int tr[7] = '{5, 10, 13, 255, 0, 3, 5};
        int tx[7] = '{3, 3, 12, 0, 0, 5, 4};
        int rr, xx, lat, bn, yv, ev, ey, ee;
        for (int i = 0; i < 17; i++) begin
            if (i < 7) begin rr = tr[i]; xx = tx[i]; end
            else begin rr = $urandom_range(0, 255); xx = $urandom_range(0, 255); end
            model(rr, xx, ey, ee);
            issue(rr, xx, lat, bn, yv, ev);
            n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL basic_latency r=%0d x=%0d got %0d want 17", rr, xx, lat); end
            n_cmp++; if (yv != ey) begin n_bad++; $display("FAIL basic_y r=%0d x=%0d got %0d want %0d", rr, xx, yv, ey); end
            n_cmp++; if (ev != ee) begin n_bad++; $display("FAIL basic_err r=%0d x=%0d got %0d want %0d", rr, xx, ev, ee); end
            if (i == 0) begin
                n_cmp++; if (bn != 17) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 17", bn); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ra, xa, rb, xb, ey, ee;
        int done_at[$];
        int y_at[$];
        int e_at[$];
        ra = $urandom_range(0, 255); xa = $urandom_range(0, 255);
        rb = 0; xb = 0;
        @(negedge clk);
        bus.r = 8'(ra); bus.x = 8'(xa); bus.start = 1'b1;
        @(negedge clk);                       // after E0
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin done_at.push_back(c); y_at.push_back(int'(bus.y)); e_at.push_back(int'(bus.err)); end
            bus.r = 8'($urandom_range(0, 255));
            bus.x = 8'($urandom_range(0, 255));
            if (c == 17) begin rb = int'(bus.r); xb = int'(bus.x); end
            if (c == 35) bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_cmp++;
        if (done_at.size() != 2) begin
            n_bad++; $display("FAIL b2b_done_count got %0d want 2", done_at.size());
        end else begin
            n_cmp++; if (done_at[0] != 17) begin n_bad++; $display("FAIL b2b_first_done got %0d want 17", done_at[0]); end
            n_cmp++; if (done_at[1] - done_at[0] != 18) begin n_bad++; $display("FAIL b2b_spacing got %0d want 18", done_at[1] - done_at[0]); end
            model(ra, xa, ey, ee);
            n_cmp++; if (y_at[0] != ey || e_at[0] != ee) begin n_bad++; $display("FAIL b2b_res0 got y=%0d e=%0d want y=%0d e=%0d", y_at[0], e_at[0], ey, ee); end
            model(rb, xb, ey, ee);
            n_cmp++; if (y_at[1] != ey || e_at[1] != ee) begin n_bad++; $display("FAIL b2b_res1 got y=%0d e=%0d want y=%0d e=%0d", y_at[1], e_at[1], ey, ee); end
        end
    endtask

    task automatic test_ena();
        int rr, xx, ey, ee, k, prev;
        bit seen;
        rr = $urandom_range(128, 255); xx = $urandom_range(0, 127);
        model(rr, xx, ey, ee);
        @(negedge clk);
        prev = int'(bus.y);
        bus.r = 8'(rr); bus.x = 8'(xx); bus.start = 1'b1;
        @(negedge clk);                       // after E0
        bus.start = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 60) begin
            bus.ena = (k >= 11 && k <= 15) ? 1'b0 : 1'b1;
            @(negedge clk);
            k++;
            if (k >= 12 && k <= 16) begin
                n_cmp++; if (int'(bus.y) != prev) begin n_bad++; $display("FAIL ena_y_frozen edge=%0d got %0d want %0d", k, bus.y, prev); end
            end
            if (bus.done) seen = 1;
        end
        bus.ena = 1'b1;
        n_cmp++; if (k != 22) begin n_bad++; $display("FAIL ena_latency got %0d want 22", k); end
        n_cmp++; if (int'(bus.y) != ey) begin n_bad++; $display("FAIL ena_y got %0d want %0d", bus.y, ey); end
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ena_done_hold cycle=%0d got %b want 1", i, bus.done); end
        end
        bus.ena = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ena_done_clear got %b want 0", bus.done); end
    endtask

    task automatic test_reset_mid();
        int lat, bn, yv, ev, ey, ee;
        bit seen;
        @(negedge clk);
        bus.r = 8'd200; bus.x = 8'd100; bus.start = 1'b1;
        @(negedge clk);                       // after E0
        bus.start = 1'b0;
        repeat (5) @(negedge clk);            // after E5
        rst = 1'b1;
        @(negedge clk);                       // after E6
        rst = 1'b0;
        n_cmp++; if (bus.y !== 8'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_outputs got y=%0d d=%b b=%b e=%b want all 0", bus.y, bus.done, bus.busy, bus.err);
        end
        seen = 0;
        repeat (25) begin @(negedge clk); if (bus.done) seen = 1; end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL rstmid_no_done got done want none"); end
        // reset and start on the same edge: not accepted
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_start_busy got %b want 0", bus.busy); end
        model(200, 120, ey, ee);
        issue(200, 120, lat, bn, yv, ev);
        n_cmp++; if (yv != ey || ev != ee || lat != 17) begin
            n_bad++; $display("FAIL rstmid_next got y=%0d e=%0d lat=%0d want y=%0d e=%0d lat=17", yv, ev, lat, ey, ee);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ena();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
